// File: rtl/ic_pkg.sv
// Shared types for the icache miss/fill scheduler: xid type, per-xid entry
// state and the saturating increment used by the IC_FILL_STATS_EN counters.
package ic_pkg;

    localparam int IC_NXID = 4;
    localparam int IC_NCTX = 8;
    localparam int IC_AW   = 23;

    typedef logic [$clog2(IC_NXID)-1:0] ic_xid_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2
    } ic_fill_state_e;

    typedef struct packed {
        ic_fill_state_e       state;
        logic [IC_AW-1:0]     addr;
        logic [IC_NCTX-1:0]   ctx_mask;
    } ic_fill_entry_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/ic_pri_enc.sv
// Lowest-index priority encoder with a valid flag.
module ic_pri_enc #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ic_fill_sched.sv
// Icache miss/fill scheduler: allocates xids, merges duplicate misses, issues
// line reads and reports fills. Define IC_FILL_STATS_EN for the stat counters.
module ic_fill_sched
    import ic_pkg::*;
#(
    parameter int NXID = IC_NXID,
    parameter int NCTX = IC_NCTX
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    miss_valid,
    input  logic [IC_AW-1:0]        miss_addr,
    input  logic [$clog2(NCTX)-1:0] miss_ctx,
    output logic                    miss_ready,
    output logic [IC_AW-1:0]        ic_mem_addr,
    output logic [$clog2(NXID)-1:0] ic_mem_xid,
    output logic                    ic_mem_re,
    input  logic                    mem_ic_ready,
    input  logic                    mem_ic_valid,
    input  logic [$clog2(NXID)-1:0] mem_ic_xid,
    output logic                    fill_valid,
    output logic [IC_AW-1:0]        fill_addr,
    output logic [$clog2(NXID)-1:0] fill_xid,
    output logic [NCTX-1:0]         fill_ctx_mask,
    output logic                    busy,
    output logic [15:0]             stat_miss,
    output logic [15:0]             stat_merge,
    output logic [15:0]             stat_fill
);

    localparam int XW = $clog2(NXID);

    ic_fill_entry_t ent_q [NXID];
    ic_fill_entry_t ent_d [NXID];

    logic [NXID-1:0] free_vec, match_vec, freeing, pend_d_vec;
    logic [XW-1:0]   free_idx, match_idx, pend_idx;
    logic            free_any, match_any, pend_any;
    logic            resp_hit, accept, hs, busy_d;
    logic [NCTX-1:0] ctx_bit;

    logic            ic_mem_re_q;
    logic [IC_AW-1:0] ic_mem_addr_q;
    logic [XW-1:0]   ic_mem_xid_q;
    logic            fill_valid_q, busy_q;
    logic [IC_AW-1:0] fill_addr_q;
    logic [XW-1:0]   fill_xid_q;
    logic [NCTX-1:0] fill_ctx_mask_q;

    // Responses only count against ISSUED entries; anything else is stray.
    assign resp_hit = mem_ic_valid && (ent_q[mem_ic_xid].state == ISSUED);
    assign ctx_bit  = NCTX'(1) << miss_ctx;

    always_comb begin
        for (int i = 0; i < NXID; i++) begin
            free_vec[i]  = (ent_q[i].state == FREE);
            freeing[i]   = resp_hit && (mem_ic_xid == XW'(i));
            match_vec[i] = (ent_q[i].state != FREE) && (ent_q[i].addr == miss_addr) && !freeing[i];
        end
    end

    ic_pri_enc #(.N(NXID), .W(XW)) u_free  (.req_i(free_vec),   .idx_o(free_idx),  .valid_o(free_any));
    ic_pri_enc #(.N(NXID), .W(XW)) u_match (.req_i(match_vec),  .idx_o(match_idx), .valid_o(match_any));
    ic_pri_enc #(.N(NXID), .W(XW)) u_pend  (.req_i(pend_d_vec), .idx_o(pend_idx),  .valid_o(pend_any));

    assign miss_ready = match_any | free_any;
    assign accept     = miss_valid & miss_ready;
    assign hs         = ic_mem_re_q & mem_ic_ready;

    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NXID; i++) begin
            ent_d[i] = ent_q[i];
            if (hs && ic_mem_xid_q == XW'(i))
                ent_d[i].state = ISSUED;
            if (freeing[i]) begin
                ent_d[i].state    = FREE;
                ent_d[i].ctx_mask = '0;
            end
            if (accept && match_any && match_idx == XW'(i))
                ent_d[i].ctx_mask = ent_q[i].ctx_mask | ctx_bit;
            else if (accept && !match_any && free_idx == XW'(i))
                ent_d[i] = '{PEND, miss_addr, ctx_bit};
            pend_d_vec[i] = (ent_d[i].state == PEND);
            busy_d        = busy_d | (ent_d[i].state != FREE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NXID; i++)
                ent_q[i] <= '{FREE, '0, '0};
            ic_mem_re_q     <= 1'b0;
            ic_mem_addr_q   <= '0;
            ic_mem_xid_q    <= '0;
            fill_valid_q    <= 1'b0;
            fill_addr_q     <= '0;
            fill_xid_q      <= '0;
            fill_ctx_mask_q <= '0;
            busy_q          <= 1'b0;
        end else begin
            for (int i = 0; i < NXID; i++)
                ent_q[i] <= ent_d[i];
            // A stalled request stays put; re-select only once it is taken.
            if (!(ic_mem_re_q && !mem_ic_ready)) begin
                ic_mem_re_q <= pend_any;
                if (pend_any) begin
                    ic_mem_addr_q <= ent_d[pend_idx].addr;
                    ic_mem_xid_q  <= pend_idx;
                end
            end
            fill_valid_q <= resp_hit;
            if (resp_hit) begin
                fill_addr_q     <= ent_q[mem_ic_xid].addr;
                fill_xid_q      <= mem_ic_xid;
                fill_ctx_mask_q <= ent_q[mem_ic_xid].ctx_mask;
            end
            busy_q <= busy_d;
        end
    end

    assign ic_mem_re     = ic_mem_re_q;
    assign ic_mem_addr   = ic_mem_addr_q;
    assign ic_mem_xid    = ic_mem_xid_q;
    assign fill_valid    = fill_valid_q;
    assign fill_addr     = fill_addr_q;
    assign fill_xid      = fill_xid_q;
    assign fill_ctx_mask = fill_ctx_mask_q;
    assign busy          = busy_q;

`ifdef IC_FILL_STATS_EN
    logic [15:0] stat_miss_q, stat_merge_q, stat_fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_miss_q  <= '0;
            stat_merge_q <= '0;
            stat_fill_q  <= '0;
        end else begin
            stat_miss_q  <= sat_inc(stat_miss_q, accept);
            stat_merge_q <= sat_inc(stat_merge_q, accept && match_any);
            stat_fill_q  <= sat_inc(stat_fill_q, resp_hit);
        end
    end

    assign stat_miss  = stat_miss_q;
    assign stat_merge = stat_merge_q;
    assign stat_fill  = stat_fill_q;
`else
    assign stat_miss  = '0;
    assign stat_merge = '0;
    assign stat_fill  = '0;
`endif

endmodule

// File: tb/tb_ic_fill_sched.sv
// Bench for ic_fill_sched: directed scenarios plus random traffic, all checked
// against a transaction-level model of the entry table.
module tb_ic_fill_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_valid = 1'b0;
    logic [22:0] miss_addr = '0;
    logic [2:0]  miss_ctx = '0;
    logic        miss_ready;
    logic [22:0] ic_mem_addr;
    logic [1:0]  ic_mem_xid;
    logic        ic_mem_re;
    logic        mem_ic_ready = 1'b0;
    logic        mem_ic_valid = 1'b0;
    logic [1:0]  mem_ic_xid = '0;
    logic        fill_valid;
    logic [22:0] fill_addr;
    logic [1:0]  fill_xid;
    logic [7:0]  fill_ctx_mask;
    logic        busy;
    logic [15:0] stat_miss, stat_merge, stat_fill;

    ic_fill_sched dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ctx(miss_ctx), .miss_ready(miss_ready),
        .ic_mem_addr(ic_mem_addr), .ic_mem_xid(ic_mem_xid), .ic_mem_re(ic_mem_re), .mem_ic_ready(mem_ic_ready),
        .mem_ic_valid(mem_ic_valid), .mem_ic_xid(mem_ic_xid),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_xid(fill_xid), .fill_ctx_mask(fill_ctx_mask),
        .busy(busy), .stat_miss(stat_miss), .stat_merge(stat_merge), .stat_fill(stat_fill)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs = 0;

    // Model: 0=free 1=pending 2=issued per xid, plus expected registered outputs.
    int          st [4];
    logic [22:0] ad [4];
    logic [7:0]  mk [4];
    bit          e_re, e_fv, e_busy;
    logic [22:0] e_addr, e_faddr;
    int          e_xid, e_fxid;
    logic [7:0]  e_fmask;
    int          e_smiss, e_smerge, e_sfill;
    logic        mr_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 4; j++) begin
            st[j] = 0; ad[j] = '0; mk[j] = '0;
        end
        e_re = 0; e_fv = 0; e_busy = 0; e_addr = '0; e_faddr = '0;
        e_xid = 0; e_fxid = 0; e_fmask = '0;
        e_smiss = 0; e_smerge = 0; e_sfill = 0;
    endtask

    task automatic compare_outs();
        chk("ic_mem_re", 32'(ic_mem_re), 32'(e_re));
        chk("fill_valid", 32'(fill_valid), 32'(e_fv));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_re) begin
            chk("ic_mem_addr", 32'(ic_mem_addr), 32'(e_addr));
            chk("ic_mem_xid", 32'(ic_mem_xid), 32'(e_xid));
        end
        if (e_fv) begin
            chk("fill_addr", 32'(fill_addr), 32'(e_faddr));
            chk("fill_xid", 32'(fill_xid), 32'(e_fxid));
            chk("fill_ctx_mask", 32'(fill_ctx_mask), 32'(e_fmask));
        end
`ifdef IC_FILL_STATS_EN
        chk("stat_miss", 32'(stat_miss), 32'(e_smiss));
        chk("stat_merge", 32'(stat_merge), 32'(e_smerge));
        chk("stat_fill", 32'(stat_fill), 32'(e_sfill));
`else
        chk("stat_off", 32'({stat_miss, stat_merge} | 32'(stat_fill)), 32'd0);
`endif
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge with
    // the registered outputs of the intervening posedge already checked.
    task automatic step(input logic mv, input logic [22:0] ma, input logic [2:0] mc,
                        input logic mr, input logic rv, input logic [1:0] rx);
        int m, f;
        bit hit, acc, hs, exp_ready;
        miss_valid = mv; miss_addr = ma; miss_ctx = mc;
        mem_ic_ready = mr; mem_ic_valid = rv; mem_ic_xid = rx;
        #1;
        hit = rv && st[rx] == 2;
        m = -1; f = -1;
        for (int j = 0; j < 4; j++) begin
            if (m < 0 && st[j] != 0 && ad[j] == ma && !(hit && j == int'(rx))) m = j;
            if (f < 0 && st[j] == 0) f = j;
        end
        exp_ready = (m >= 0) || (f >= 0);
        mr_seen = miss_ready;
        chk("miss_ready", 32'(miss_ready), 32'(exp_ready));
        acc = mv && exp_ready;
        hs = e_re && mr;
        e_fv = hit;
        if (hit) begin
            e_faddr = ad[rx]; e_fxid = int'(rx); e_fmask = mk[rx];
        end
        if (hs) st[e_xid] = 2;
        if (hit) begin
            st[rx] = 0; mk[rx] = '0;
        end
        if (acc) begin
            if (m >= 0) mk[m] = mk[m] | (8'(1) << mc);
            else begin
                st[f] = 1; ad[f] = ma; mk[f] = 8'(1) << mc;
            end
        end
        if (acc && e_smiss < 65535) e_smiss++;
        if (acc && m >= 0 && e_smerge < 65535) e_smerge++;
        if (hit && e_sfill < 65535) e_sfill++;
        if (!(e_re && !mr)) begin
            e_re = 0;
            for (int j = 3; j >= 0; j--)
                if (st[j] == 1) begin
                    e_re = 1; e_addr = ad[j]; e_xid = j;
                end
        end
        e_busy = 0;
        for (int j = 0; j < 4; j++) if (st[j] != 0) e_busy = 1;
        @(posedge clk);
        @(negedge clk);
        compare_outs();
    endtask

    // Reset held low for one full cycle, outputs checked while it is low.
    task automatic do_reset();
        rst_n = 1'b0;
        miss_valid = 0; mem_ic_valid = 0; mem_ic_ready = 0;
        model_reset();
        #1;
        chk("rst_re", 32'(ic_mem_re), 0);
        chk("rst_mem", 32'({ic_mem_addr, ic_mem_xid}), 0);
        chk("rst_fill", 32'({fill_valid, fill_xid, fill_ctx_mask}), 0);
        chk("rst_faddr", 32'(fill_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stats", 32'({stat_miss, stat_merge} | 32'(stat_fill)), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          mv, rv, mr;
        logic [22:0] ma;
        logic [2:0]  mc;
        logic [1:0]  rx;
        int          iss [$];

        @(negedge clk);
        do_reset();

        // Single miss, response four cycles after issue.
        step(1, 23'h1000, 3'd2, 1, 0, 2'd0);
        chk("s1_re", 32'(ic_mem_re), 1);
        chk("s1_xid", 32'(ic_mem_xid), 0);
        chk("s1_addr", 32'(ic_mem_addr), 32'h1000);
        for (int k = 0; k < 4; k++) step(0, '0, '0, 1, 0, 2'd0);
        step(0, '0, '0, 1, 1, 2'd0);
        chk("s1_fill", 32'(fill_valid), 1);
        chk("s1_mask", 32'(fill_ctx_mask), 32'h04);

        // Duplicate miss merges into the in-flight line.
        do_reset();
        step(1, 23'h20, 3'd1, 1, 0, 2'd0);
        step(1, 23'h20, 3'd5, 1, 0, 2'd0);
        chk("s2_one_req", 32'(ic_mem_re), 0);
        step(0, '0, '0, 1, 1, 2'd0);
        chk("s2_mask", 32'(fill_ctx_mask), 32'h22);
`ifdef IC_FILL_STATS_EN
        chk("s2_merge", 32'(stat_merge), 1);
`endif

        // Table full, then a freed xid is reused one cycle later.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 23'h300 + 23'(k), 3'd0, 1, 0, 2'd0);
            chk("s3_xid", 32'(ic_mem_xid), 32'(k));
        end
        step(1, 23'h304, 3'd0, 1, 0, 2'd0);
        chk("s3_full", 32'(mr_seen), 0);
        step(1, 23'h304, 3'd0, 1, 1, 2'd2);
        chk("s3_freeing", 32'(mr_seen), 0);
        step(1, 23'h304, 3'd0, 1, 0, 2'd0);
        chk("s3_accept", 32'(mr_seen), 1);
        chk("s3_realloc", 32'({ic_mem_re, ic_mem_xid}), 32'b110);

        // Memory stall holds the request; then out-of-order responses.
        do_reset();
        step(1, 23'h400, 3'd0, 0, 0, 2'd0);
        step(1, 23'h401, 3'd3, 0, 0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            chk("s4_hold_xid", 32'(ic_mem_xid), 0);
            chk("s4_hold_addr", 32'(ic_mem_addr), 32'h400);
            step(0, '0, '0, (k == 2), 0, 2'd0);
        end
        chk("s4_next", 32'(ic_mem_xid), 1);
        step(0, '0, '0, 1, 0, 2'd0);
        step(0, '0, '0, 1, 1, 2'd1);
        chk("s5_addr1", 32'(fill_addr), 32'h401);
        step(0, '0, '0, 1, 1, 2'd0);
        chk("s5_addr0", 32'(fill_addr), 32'h400);
        step(0, '0, '0, 1, 1, 2'd3);
        chk("s5_stray", 32'(fill_valid), 0);

        // Reset with lines in flight drops them.
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 23'h500 + 23'(k), 3'd0, 1, 0, 2'd0);
        step(0, '0, '0, 1, 0, 2'd0);
        step(0, '0, '0, 1, 0, 2'd0);
        chk("s6_busy", 32'(busy), 1);
        do_reset();
        step(0, '0, '0, 1, 1, 2'd1);
        chk("s6_ignored", 32'(fill_valid), 0);
        step(1, 23'h600, 3'd0, 1, 0, 2'd0);
        chk("s6_xid0", 32'({ic_mem_re, ic_mem_xid}), 32'b100);

        // Random traffic over a small address pool to force merges.
        mv = 0; ma = '0; mc = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            if (!(miss_valid && !mr_seen)) begin
                mv = ($urandom_range(0, 99) < 55);
                ma = 23'h7000 + 23'($urandom_range(0, 7));
                mc = 3'($urandom_range(0, 7));
            end
            mr = ($urandom_range(0, 99) < 70);
            rv = ($urandom_range(0, 99) < 40);
            iss.delete();
            for (int j = 0; j < 4; j++) if (st[j] == 2) iss.push_back(j);
            if (iss.size() > 0 && $urandom_range(0, 3) != 0)
                rx = 2'(iss[$urandom_range(0, iss.size() - 1)]);
            else
                rx = 2'($urandom_range(0, 3));
            step(mv, ma, mc, mr, rv, rx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
